sdp_mrdma_cq_arb: RTL and testbench
===================================

SDP_MRDMA_CQ_ARB -- requirements
Module: sdp_mrdma_cq_arb

Two MRDMA read-context requesters share one 128-entry context queue (cq, 14-bit entries). The block arbitrates between them and limits how many entries are outstanding in the queue.

Interface
REQ-001 The block SHALL have these ports, one per line, as name, direction, width and meaning:
- nvdla_core_clk_mgated  in  1  clock; all state is on its rising edge
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- req0_pvld  in  1  requester 0 context valid
- req0_prdy  out  1  requester 0 context accepted
- req0_pd  in  13  requester 0 context payload
- req1_pvld  in  1  requester 1 context valid
- req1_prdy  out  1  requester 1 context accepted
- req1_pd  in  13  requester 1 context payload
- ig2cq_pvld  out  1  context valid toward cq write side
- ig2cq_prdy  in  1  cq accepting
- ig2cq_pd  out  14  {src_id, payload}
- cq_pop  in  1  one cq entry consumed by egress (cq2eg_pvld && cq2eg_prdy)
- cfg_enable  in  1  grants allowed
- cfg_limit  in  8  outstanding-entry limit; 0 means 128
- outstanding  out  8  entries granted and not yet popped
- pop_underflow  out  1  sticky error flag
- arb_idle  out  1  no outstanding entries and output stage empty

Function
REQ-002 Output stage SHALL be one register (vld, 14-bit pd); ig2cq_pd SHALL stay stable while ig2cq_pvld=1 and ig2cq_prdy=0.
REQ-003 The output stage SHALL be free in a cycle when out_vld=0 or ig2cq_prdy=1.
REQ-004 Effective limit L SHALL be 128 when cfg_limit=0 or cfg_limit>128; otherwise L SHALL equal cfg_limit.
REQ-005 A grant SHALL occur only when cfg_enable=1, the output stage is free, outstanding<L and at least one reqX_pvld=1.
REQ-006 Arbitration SHALL be round-robin on a 1-bit last_grant pointer.
REQ-007 If both requesters are valid, the grant SHALL go to the requester not equal to last_grant; if one is valid, the grant SHALL go to it.
REQ-008 last_grant SHALL update only on a grant.
REQ-009 reqX_prdy SHALL be 1 only in the cycle requester X is granted; the two SHALL never both be 1.
REQ-010 reqX_prdy SHALL be 0 whenever reqX_pvld=0.
REQ-011 On a grant, the output register SHALL load vld=1 and pd={X, reqX_pd}, where X is the granted requester index.
REQ-012 Latency SHALL be one cycle: a payload accepted in cycle N appears on ig2cq_pd in cycle N+1.
REQ-013 A free output stage with no grant SHALL clear vld to 0.
REQ-014 When the output stage is free and a grant occurs in the same cycle, the register SHALL reload, allowing back-to-back one entry per cycle.
REQ-015 The outstanding counter (8 bits, range 0..128) SHALL update per cycle as follows:
- +1 on a grant
- -1 on cq_pop when outstanding>0
- unchanged on a simultaneous grant and pop
REQ-016 cq_pop with outstanding=0 and no same-cycle grant SHALL leave outstanding at 0 and set pop_underflow; pop_underflow SHALL clear only on reset.
REQ-017 cq_pop with outstanding=0 and a same-cycle grant SHALL count the grant and not the pop: outstanding becomes 1 and pop_underflow is set.
REQ-018 outstanding SHALL never exceed 128; the grant gating in REQ-005 guarantees this.
REQ-019 Lowering cfg_limit below the current outstanding value SHALL only block new grants; entries already outstanding drain normally.
REQ-020 cfg_enable=0 SHALL block new grants only; a pending output entry SHALL still complete its ig2cq handshake, and cq_pop SHALL still decrement outstanding.
REQ-021 arb_idle SHALL be registered and equal (outstanding==0 && out_vld==0) as of the previous cycle's state.

Reset
REQ-022 While nvdla_core_rstn=0, the block SHALL hold: out_vld=0, ig2cq_pd=0, outstanding=0, last_grant=1, pop_underflow=0, arb_idle=1.
REQ-023 With last_grant=1 after reset, requester 0 SHALL win the first simultaneous request.
REQ-024 Reset asserted mid-transfer SHALL drop ig2cq_pvld immediately (asynchronous) and discard the pending entry and all counts.
REQ-025 reqX_prdy SHALL be 0 during reset.

Verification
REQ-026 The bench SHALL cover at least these directed scenarios, stimulus -> required response:
- Both requesters valid continuously, ig2cq_prdy=1, cfg_limit=0 -> grants alternate 0,1,0,1; ig2cq_pd[13] alternates; one entry per cycle; outstanding rises by 1 per cycle.
- cfg_limit=4, no cq_pop, req0 always valid -> exactly 4 grants; outstanding=4; req0_prdy stays 0. One cq_pop -> exactly one further grant next cycle.
- ig2cq_prdy=0 for 5 cycles with out_vld=1 -> ig2cq_pd constant; no reqX_prdy; release -> entry accepted and the next grant occurs in the same cycle.
- outstanding=128, cq_pop and a request in the same cycle -> outstanding stays 128; grant blocked that cycle (128 is not below L); following cycle outstanding=127 and a grant is issued.
- cq_pop with outstanding=0 -> outstanding stays 0; pop_underflow=1 and remains 1 until reset.
- cfg_enable dropped with out_vld=1 and outstanding=3, then 3 cq_pop and ig2cq_prdy=1 -> entry drains; outstanding reaches 0; arb_idle=1 one cycle later. Reset asserted mid-run -> all outputs at REQ-022 values.

Source files
------------

// File: rtl/sdp_mrdma_cq_arb.sv
// rtl/sdp_mrdma_cq_arb.sv - round-robin arbiter of two MRDMA context requesters into the shared cq, with outstanding-entry limiting
module sdp_mrdma_cq_arb (
    input  logic        nvdla_core_clk_mgated,
    input  logic        nvdla_core_rstn,
    input  logic        req0_pvld,
    output logic        req0_prdy,
    input  logic [12:0] req0_pd,
    input  logic        req1_pvld,
    output logic        req1_prdy,
    input  logic [12:0] req1_pd,
    output logic        ig2cq_pvld,
    input  logic        ig2cq_prdy,
    output logic [13:0] ig2cq_pd,
    input  logic        cq_pop,
    input  logic        cfg_enable,
    input  logic [7:0]  cfg_limit,
    output logic [7:0]  outstanding,
    output logic        pop_underflow,
    output logic        arb_idle
);

    localparam logic [7:0] CQ_DEPTH = 8'd128;

    logic        out_vld_q;
    logic [13:0] out_pd_q;
    logic [7:0]  outstanding_q;
    logic [7:0]  outstanding_d;
    logic        last_grant_q;
    logic        pop_underflow_q;
    logic        pop_underflow_d;
    logic        arb_idle_q;

    logic [7:0]  eff_limit;
    logic        stage_free;
    logic        can_grant;
    logic        gnt0;
    logic        gnt1;
    logic        gnt;
    logic [13:0] gnt_pd;
    logic        pop_dec;

    // Grant decision: limit clamp, free output stage, round-robin between requesters
    always_comb begin
        eff_limit  = ((cfg_limit == 8'd0) || (cfg_limit > CQ_DEPTH)) ? CQ_DEPTH : cfg_limit;
        stage_free = !out_vld_q || ig2cq_prdy;
        can_grant  = cfg_enable && stage_free && (outstanding_q < eff_limit);
        // last_grant=1 favours requester 0 on a tie, last_grant=0 favours requester 1
        gnt0       = can_grant && req0_pvld && (!req1_pvld || last_grant_q);
        gnt1       = can_grant && req1_pvld && (!req0_pvld || !last_grant_q);
        gnt        = gnt0 || gnt1;
        gnt_pd     = gnt1 ? {1'b1, req1_pd} : {1'b0, req0_pd};
    end

    // Outstanding count and underflow flag next state; a pop with nothing outstanding is never counted
    always_comb begin
        pop_dec         = cq_pop && (outstanding_q != 8'd0);
        outstanding_d   = outstanding_q;
        pop_underflow_d = pop_underflow_q || (cq_pop && (outstanding_q == 8'd0));
        case ({gnt, pop_dec})
            2'b10:   outstanding_d = outstanding_q + 8'd1;
            2'b01:   outstanding_d = outstanding_q - 8'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Output register: reloads whenever the stage is free, clearing vld when nothing is granted
    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_vld_q <= 1'b0;
            out_pd_q  <= 14'd0;
        end else if (stage_free) begin
            out_vld_q <= gnt;
            if (gnt) begin
                out_pd_q <= gnt_pd;
            end
        end
    end

    // Round-robin pointer moves only on a grant
    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            last_grant_q <= 1'b1;
        end else if (gnt) begin
            last_grant_q <= gnt1;
        end
    end

    // Outstanding counter, sticky underflow and registered idle status
    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            outstanding_q   <= 8'd0;
            pop_underflow_q <= 1'b0;
            arb_idle_q      <= 1'b1;
        end else begin
            outstanding_q   <= outstanding_d;
            pop_underflow_q <= pop_underflow_d;
            arb_idle_q      <= (outstanding_q == 8'd0) && !out_vld_q;
        end
    end

    // Ready is forced low while reset is asserted since grant logic is combinational
    assign req0_prdy     = gnt0 && nvdla_core_rstn;
    assign req1_prdy     = gnt1 && nvdla_core_rstn;
    assign ig2cq_pvld    = out_vld_q;
    assign ig2cq_pd      = out_pd_q;
    assign outstanding   = outstanding_q;
    assign pop_underflow = pop_underflow_q;
    assign arb_idle      = arb_idle_q;

endmodule

// File: tb/tb_sdp_mrdma_cq_arb.sv
// tb/tb_sdp_mrdma_cq_arb.sv - randomized and directed bench for sdp_mrdma_cq_arb against a reference model
module tb_sdp_mrdma_cq_arb;

    logic        clk;
    logic        rstn;
    logic        req0_pvld;
    logic        req0_prdy;
    logic [12:0] req0_pd;
    logic        req1_pvld;
    logic        req1_prdy;
    logic [12:0] req1_pd;
    logic        ig2cq_pvld;
    logic        ig2cq_prdy;
    logic [13:0] ig2cq_pd;
    logic        cq_pop;
    logic        cfg_enable;
    logic [7:0]  cfg_limit;
    logic [7:0]  outstanding;
    logic        pop_underflow;
    logic        arb_idle;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_vld;
    int m_pd;
    int m_out;
    int m_last;
    bit m_uf;
    bit m_idle;
    int last_g;
    int gcount;

    sdp_mrdma_cq_arb dut (
        .nvdla_core_clk_mgated (clk),
        .nvdla_core_rstn       (rstn),
        .req0_pvld             (req0_pvld),
        .req0_prdy             (req0_prdy),
        .req0_pd               (req0_pd),
        .req1_pvld             (req1_pvld),
        .req1_prdy             (req1_prdy),
        .req1_pd               (req1_pd),
        .ig2cq_pvld            (ig2cq_pvld),
        .ig2cq_prdy            (ig2cq_prdy),
        .ig2cq_pd              (ig2cq_pd),
        .cq_pop                (cq_pop),
        .cfg_enable            (cfg_enable),
        .cfg_limit             (cfg_limit),
        .outstanding           (outstanding),
        .pop_underflow         (pop_underflow),
        .arb_idle              (arb_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_vld  = 1'b0;
        m_pd   = 0;
        m_out  = 0;
        m_last = 1;
        m_uf   = 1'b0;
        m_idle = 1'b1;
    endfunction

    // which requester the rules say wins this cycle, -1 for none
    function automatic int pred_grant(bit v0, bit v1, bit rdy, bit en, int lim);
        int l;
        l = (lim == 0 || lim > 128) ? 128 : lim;
        if (!en || !(!m_vld || rdy) || m_out >= l) return -1;
        if (v0 && v1) return 1 - m_last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // one clock: drive, check ready before the edge, advance model, check registered outputs after
    task automatic cyc(input bit v0, input int p0, input bit v1, input int p1,
                       input bit rdy, input bit pop, input bit en, input int lim);
        int  g;
        bit  free;
        req0_pvld  = v0;
        req0_pd    = 13'(p0);
        req1_pvld  = v1;
        req1_pd    = 13'(p1);
        ig2cq_prdy = rdy;
        cq_pop     = pop;
        cfg_enable = en;
        cfg_limit  = 8'(lim);
        #2;
        g = pred_grant(v0, v1, rdy, en, lim);
        free = !m_vld || rdy;
        chk("req0_prdy", 32'(req0_prdy), 32'(g == 0));
        chk("req1_prdy", 32'(req1_prdy), 32'(g == 1));
        last_g = g;
        if (g >= 0) gcount++;
        @(posedge clk);
        m_idle = (m_out == 0) && !m_vld;
        if (free) begin
            m_vld = (g >= 0);
            if (g >= 0) m_pd = (g << 13) | ((g == 0) ? (p0 & 'h1fff) : (p1 & 'h1fff));
        end
        if (pop) begin
            if (m_out == 0) m_uf = 1'b1;
            else m_out = m_out - 1;
        end
        if (g >= 0) begin
            m_out  = m_out + 1;
            m_last = g;
        end
        #1;
        chk("ig2cq_pvld", 32'(ig2cq_pvld), 32'(m_vld));
        if (m_vld) chk("ig2cq_pd", 32'(ig2cq_pd), 32'(m_pd));
        chk("outstanding", 32'(outstanding), 32'(m_out));
        chk("pop_underflow", 32'(pop_underflow), 32'(m_uf));
        chk("arb_idle", 32'(arb_idle), 32'(m_idle));
    endtask

    // asynchronous reset with active requests present; outputs must fall immediately
    task automatic do_reset();
        req0_pvld  = 1'b1;
        req1_pvld  = 1'b1;
        cfg_enable = 1'b1;
        ig2cq_prdy = 1'b1;
        cq_pop     = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_pvld", 32'(ig2cq_pvld), 32'd0);
        chk("rst_pd", 32'(ig2cq_pd), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_underflow", 32'(pop_underflow), 32'd0);
        chk("rst_idle", 32'(arb_idle), 32'd1);
        chk("rst_prdy0", 32'(req0_prdy), 32'd0);
        chk("rst_prdy1", 32'(req1_prdy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        int pd_hold;
        int lim;
        rstn = 1'b0;
        req0_pvld = 0; req1_pvld = 0; req0_pd = 0; req1_pd = 0;
        ig2cq_prdy = 0; cq_pop = 0; cfg_enable = 0; cfg_limit = 0;
        model_reset();
        last_g = -1;
        gcount = 0;
        @(posedge clk);
        #1;
        do_reset();

        // alternating grants, one per cycle, requester 0 first
        for (int i = 0; i < 6; i++) begin
            cyc(1, $urandom, 1, $urandom, 1, 0, 1, 0);
            chk("alt_grant", 32'(last_g), 32'(i % 2));
            chk("alt_outstanding", 32'(outstanding), 32'(i + 1));
        end

        // limit of 4 with no pops, then a single pop releases exactly one grant
        do_reset();
        gcount = 0;
        for (int i = 0; i < 7; i++) cyc(1, $urandom, 0, 0, 1, 0, 1, 4);
        chk("lim4_grants", 32'(gcount), 32'd4);
        chk("lim4_outstanding", 32'(outstanding), 32'd4);
        gcount = 0;
        cyc(1, $urandom, 0, 0, 1, 1, 1, 4);
        for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0, 1, 0, 1, 4);
        chk("lim4_one_more", 32'(gcount), 32'd1);

        // stall the output for 5 cycles, then release with a same-cycle grant
        do_reset();
        cyc(1, $urandom, 1, $urandom, 1, 0, 1, 0);
        pd_hold = 32'(ig2cq_pd);
        gcount = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, $urandom, 1, $urandom, 0, 0, 1, 0);
            chk("stall_pd", 32'(ig2cq_pd), 32'(pd_hold));
        end
        chk("stall_no_grant", 32'(gcount), 32'd0);
        cyc(1, $urandom, 1, $urandom, 1, 0, 1, 0);
        chk("release_grant", 32'(last_g), 32'd1);

        // fill to 128, pop and request together at the ceiling
        do_reset();
        for (int i = 0; i < 130; i++) cyc(1, $urandom, $urandom_range(0, 1), $urandom, 1, 0, 1, 0);
        chk("full_128", 32'(outstanding), 32'd128);
        cyc(1, $urandom, 1, $urandom, 1, 1, 1, 0);
        chk("ceiling_blocked", 32'(last_g), 32'hffffffff);
        chk("ceiling_count", 32'(outstanding), 32'd127);
        cyc(1, $urandom, 0, 0, 1, 0, 1, 200);
        chk("ceiling_regrant", 32'(last_g), 32'd0);

        // underflow is sticky until reset
        do_reset();
        cyc(0, 0, 0, 0, 1, 1, 1, 0);
        chk("uf_set", 32'(pop_underflow), 32'd1);
        chk("uf_outstanding", 32'(outstanding), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, 0, 1, $urandom_range(0, 1), 1, 0);
        chk("uf_sticky", 32'(pop_underflow), 32'd1);

        // disable with a pending entry and 3 outstanding, then drain
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 1, $urandom, 1, 0, 1, 0);
        chk("drain_start_vld", 32'(ig2cq_pvld), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 1, $urandom, 1, 1, 0, 0);
        chk("drain_zero", 32'(outstanding), 32'd0);
        chk("drain_vld", 32'(ig2cq_pvld), 32'd0);
        cyc(1, $urandom, 1, $urandom, 1, 0, 0, 0);
        chk("drain_idle", 32'(arb_idle), 32'd1);

        // randomized traffic with a reset in the middle
        lim = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: lim = 0;
                    1: lim = $urandom_range(1, 10);
                    2: lim = 200;
                    default: lim = 128;
                endcase
            end
            cyc($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
                $urandom_range(0, 19) != 0, lim);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
